// File: rtl/fsk_frame_scheduler_pkg.sv
// Shared types and default timing constants for the FSK frame scheduler.
package fsk_frame_scheduler_pkg;

  localparam int unsigned DefSymDiv       = 4;
  localparam int unsigned DefPreambleBits = 8;
  localparam int unsigned DefGapSyms      = 2;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StStart,
    StData,
    StStop,
    StGap
  } fsk_state_e;

endpackage

// File: rtl/fsk_sym_timer.sv
// Symbol-period counter: counts 0..SYM_DIV-1 while enabled, held at 0 otherwise.
module fsk_sym_timer
  import fsk_frame_scheduler_pkg::*;
#(
  parameter int unsigned SYM_DIV = DefSymDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sym_tick
);

  localparam logic [15:0] CntMax = 16'(SYM_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sym_tick = en && (cnt_q == CntMax);
    cnt_d    = cnt_q + 16'd1;
    if (!en || sym_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fsk_frame_scheduler.sv
// Frames payload bytes into preamble/start/data/stop/gap symbols and drives the FSK key.
module fsk_frame_scheduler
  import fsk_frame_scheduler_pkg::*;
#(
  parameter int unsigned SYM_DIV       = DefSymDiv,
  parameter int unsigned PREAMBLE_BITS = DefPreambleBits,
  parameter int unsigned GAP_SYMS      = DefGapSyms
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       key,
  output logic       phase_clr,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [7:0] PreLast = 8'(PREAMBLE_BITS - 1);
  localparam logic [7:0] GapLast = 8'(GAP_SYMS - 1);

  fsk_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       last_q, last_d;
  logic       ext_q, ext_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_last_q, hold_last_d;
  logic       key_q, key_d;
  logic       phase_clr_q, phase_clr_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;
  logic       load_shift;
  logic       sym_tick;

  assign busy      = (state_q != StIdle);
  assign s_ready   = ~hold_full_q;
  assign key       = key_q;
  assign phase_clr = phase_clr_q;
  assign done      = done_q;
  assign underrun  = underrun_q;

  fsk_sym_timer #(
    .SYM_DIV (SYM_DIV)
  ) u_sym_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (busy),
    .sym_tick (sym_tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    last_d      = last_q;
    ext_d       = ext_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    phase_clr_d = 1'b0;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    load_shift  = 1'b0;
    key_d       = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          state_d     = StPreamble;
          cnt_d       = '0;
          phase_clr_d = 1'b1;
        end
      end
      StPreamble: begin
        if (sym_tick) begin
          if (cnt_q == PreLast) begin
            state_d    = StStart;
            load_shift = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StStart: begin
        if (sym_tick) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (sym_tick) begin
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        // Without a waiting byte the stop mark is stretched; underrun flags only the first miss.
        if (sym_tick) begin
          if (last_q) begin
            state_d = StGap;
            cnt_d   = '0;
          end else if (hold_full_q) begin
            state_d    = StStart;
            load_shift = 1'b1;
            ext_d      = 1'b0;
          end else if (!ext_q) begin
            underrun_d = 1'b1;
            ext_d      = 1'b1;
          end
        end
      end
      StGap: begin
        if (sym_tick) begin
          if (cnt_q == GapLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_shift) begin
      sh_d        = hold_data_q;
      last_d      = hold_last_q;
      hold_full_d = 1'b0;
    end
    if (s_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = s_data;
      hold_last_d = s_last;
    end

    // Key is derived from the next state so it changes together with the state register.
    unique case (state_d)
      StPreamble: key_d = ~cnt_d[0];
      StStart:    key_d = 1'b0;
      StData:     key_d = sh_d[0];
      default:    key_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      last_q      <= 1'b0;
      ext_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      key_q       <= 1'b1;
      phase_clr_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      last_q      <= last_d;
      ext_q       <= ext_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      key_q       <= key_d;
      phase_clr_q <= phase_clr_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_fsk_frame_scheduler.sv
// Self-checking bench: per-cycle output trace compared against a symbol-schedule model.
module tb_fsk_frame_scheduler;

  localparam int D    = 4;
  localparam int P    = 4;
  localparam int G    = 2;
  localparam int MaxC = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready, key, phase_clr, busy, done, underrun;

  fsk_frame_scheduler #(
    .SYM_DIV       (D),
    .PREAMBLE_BITS (P),
    .GAP_SYMS      (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .key       (key),
    .phase_clr (phase_clr),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Trace bits: {key, phase_clr, done, underrun, busy}
  logic [4:0] tr [MaxC];
  logic [4:0] ex [MaxC];
  always @(negedge clk) if (cyc < MaxC) tr[cyc] <= {key, phase_clr, done, underrun, busy};

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] b_data [16];
  logic       b_last [16];
  int         b_off  [16];
  int         nb;

  task automatic do_reset(output int t0);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic fill(input int c, input logic k);
    for (int i = 0; i < D; i++) if (c + i < MaxC) ex[c + i] = {k, 3'b000, 1'b1};
  endtask

  // Expected schedule from frame rules: acceptance times, preamble, 10 symbols per byte,
  // stretched stop while no byte is waiting, gap, then done.
  task automatic build_model(input int t0, output int t_end);
    int c, acc, prev_acc, hold_free, idle_at, f, o;
    bit in_frame, first;
    for (int i = t0; i < MaxC; i++) ex[i] = 5'b10000;
    prev_acc  = t0 - 1;
    hold_free = t0;
    idle_at   = t0 - 1;
    in_frame  = 1'b0;
    c         = t0;
    for (int j = 0; j < nb; j++) begin
      o        = (b_off[j] > prev_acc + 1) ? b_off[j] : prev_acc + 1;
      acc      = (o > hold_free) ? o : hold_free;
      prev_acc = acc;
      if (!in_frame) begin
        f = (acc + 2 > idle_at + 1) ? acc + 2 : idle_at + 1;
        for (int s = 0; s < P; s++) fill(f + s * D, (s % 2) == 0);
        ex[f][3] = 1'b1;
        c        = f + P * D;
        in_frame = 1'b1;
      end else begin
        first = 1'b1;
        while (acc > c - 2) begin
          fill(c, 1'b1);
          if (first) ex[c][1] = 1'b1;
          first = 1'b0;
          c += D;
        end
      end
      hold_free = c;
      fill(c, 1'b0);
      c += D;
      for (int i = 0; i < 8; i++) begin
        fill(c, b_data[j][i]);
        c += D;
      end
      fill(c, 1'b1);
      c += D;
      if (b_last[j]) begin
        for (int s = 0; s < G; s++) fill(c + s * D, 1'b1);
        c += G * D;
        ex[c][2] = 1'b1;
        idle_at  = c;
        in_frame = 1'b0;
      end
    end
    t_end = c;
  endtask

  task automatic drive();
    int guard;
    for (int j = 0; j < nb; j++) begin
      while (cyc < b_off[j]) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b_data[j];
      s_last  = b_last[j];
      guard   = 0;
      while (!s_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      n_assert++;
      if (guard >= 2000) begin
        n_fail++;
        $display("FAIL handshake byte %0d: s_ready=%b after %0d cycles, required 1", j, s_ready,
                 guard);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b1;
  endtask

  task automatic run_frames(input int t0, output int t_end);
    build_model(t0, t_end);
    drive();
    while (cyc <= t_end + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    int t0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({key, busy, phase_clr, done, underrun, s_ready} !== 6'b100001) begin
      n_fail++;
      $display("FAIL reset_hold {key,busy,phase_clr,done,underrun,s_ready} got %b required 100001",
               {key, busy, phase_clr, done, underrun, s_ready});
    end
    do_reset(t0);
    n_assert++;
    if ({key, busy, done, s_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_release {key,busy,done,s_ready} got %b required 1001",
               {key, busy, done, s_ready});
    end
  endtask

  task automatic test_single_byte();
    int t0, t_end, nf, f;
    logic [15:0] seq;
    seq = 16'b1010_0101_0010_1111;
    do_reset(t0);
    nb = 1;
    b_data[0] = 8'hA5; b_last[0] = 1'b1; b_off[0] = t0;
    run_frames(t0, t_end);
    f  = t0 + 2;
    nf = 0;
    for (int s = 0; s < 16; s++) begin
      n_assert++;
      if (tr[f + s * D + 1][4] !== seq[15 - s]) begin
        n_fail++;
        $display("FAIL single_key symbol %0d: key=%b required %b", s, tr[f + s * D + 1][4],
                 seq[15 - s]);
      end
    end
    n_assert++;
    if (tr[f + 64][2] !== 1'b1 || tr[f + 63][2] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_time done@+63=%b done@+64=%b required 0,1", tr[f + 63][2],
               tr[f + 64][2]);
    end
    for (int c = t0; c <= t_end + 1 && nf < 8; c++) begin
      n_assert++;
      if (tr[c] !== ex[c]) begin
        nf++; n_fail++;
        $display("FAIL single_trace cyc %0d: got %b required %b", c - t0, tr[c], ex[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0, t_end, nf, f;
    do_reset(t0);
    nb = 2;
    b_data[0] = 8'h00; b_last[0] = 1'b0; b_off[0] = t0;
    b_data[1] = 8'hFF; b_last[1] = 1'b1; b_off[1] = t0;
    run_frames(t0, t_end);
    f = t0 + 2;
    n_assert++;
    if (tr[f + 26 * D][2] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_time done after 26 symbols=%b required 1", tr[f + 26 * D][2]);
    end
    nf = 0;
    for (int c = t0; c <= t_end + 1 && nf < 8; c++) begin
      n_assert++;
      if (tr[c] !== ex[c]) begin
        nf++; n_fail++;
        $display("FAIL b2b_trace cyc %0d: got %b required %b", c - t0, tr[c], ex[c]);
      end
    end
  endtask

  task automatic test_underrun();
    int t0, t_end, nf, npulse;
    do_reset(t0);
    nb = 2;
    b_data[0] = 8'h3C; b_last[0] = 1'b0; b_off[0] = t0;
    b_data[1] = 8'hC3; b_last[1] = 1'b1; b_off[1] = t0 + 2 + 14 * D + 20;
    run_frames(t0, t_end);
    npulse = 0;
    for (int c = t0; c <= t_end; c++) npulse += int'(tr[c][1]);
    n_assert++;
    if (npulse != 1) begin
      n_fail++;
      $display("FAIL underrun_count got %0d pulses required 1", npulse);
    end
    nf = 0;
    for (int c = t0; c <= t_end + 1 && nf < 8; c++) begin
      n_assert++;
      if (tr[c] !== ex[c]) begin
        nf++; n_fail++;
        $display("FAIL underrun_trace cyc %0d: got %b required %b", c - t0, tr[c], ex[c]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0, guard, nf;
    do_reset(t0);
    s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
    @(negedge clk);
    s_data = 8'h12; s_last = 1'b1;
    guard = 0;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    while (cyc < t0 + 2 + (P + 3) * D) @(negedge clk);
    n_assert++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre busy=%b required 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if ({key, busy, s_ready, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL abort_post {key,busy,s_ready,done} got %b required 1010",
               {key, busy, s_ready, done});
    end
    nf = 0;
    for (int i = 0; i < 60 && nf < 8; i++) begin
      @(negedge clk);
      n_assert++;
      if ({busy, done, phase_clr, underrun} !== 4'b0000) begin
        nf++; n_fail++;
        $display("FAIL abort_quiet cyc %0d {busy,done,phase_clr,underrun} got %b required 0000",
                 i, {busy, done, phase_clr, underrun});
      end
    end
  endtask

  task automatic test_gap_offer();
    int t0, t_end, nf, npc;
    do_reset(t0);
    nb = 2;
    b_data[0] = 8'h81; b_last[0] = 1'b1; b_off[0] = t0;
    b_data[1] = 8'h5A; b_last[1] = 1'b1; b_off[1] = t0 + 2 + 14 * D + 2;
    run_frames(t0, t_end);
    npc = 0;
    for (int c = t0; c <= t_end; c++) npc += int'(tr[c][3]);
    n_assert++;
    if (npc != 2) begin
      n_fail++;
      $display("FAIL gap_phase_clr got %0d pulses required 2", npc);
    end
    nf = 0;
    for (int c = t0; c <= t_end + 1 && nf < 8; c++) begin
      n_assert++;
      if (tr[c] !== ex[c]) begin
        nf++; n_fail++;
        $display("FAIL gap_trace cyc %0d: got %b required %b", c - t0, tr[c], ex[c]);
      end
    end
  endtask

  task automatic test_random();
    int t0, t_end, nf;
    for (int it = 0; it < 6; it++) begin
      do_reset(t0);
      nb = 1 + int'($urandom_range(0, 3));
      for (int j = 0; j < nb; j++) begin
        b_data[j] = 8'($urandom);
        b_last[j] = (j == nb - 1) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        b_off[j]  = (j == 0) ? t0 : b_off[j - 1] + int'($urandom_range(0, 40));
      end
      run_frames(t0, t_end);
      nf = 0;
      for (int c = t0; c <= t_end + 1 && nf < 8; c++) begin
        n_assert++;
        if (tr[c] !== ex[c]) begin
          nf++; n_fail++;
          $display("FAIL random_trace iter %0d cyc %0d: got %b required %b", it, c - t0, tr[c],
                   ex[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_gap_offer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
